// File: rtl/ge_tobytes_if.sv
// ge_tobytes_if: encoder request/result bus plus the borrowed multiplier port group.
interface ge_tobytes_if #(
    parameter int FE_W = 320,
    parameter int S_W  = 256
);
    logic            valid;
    logic [FE_W-1:0] p_x;
    logic [FE_W-1:0] p_y;
    logic [FE_W-1:0] p_z;
    logic [S_W-1:0]  s;
    logic            done;
    logic            busy;
    logic [FE_W-1:0] mul_op_a;
    logic [FE_W-1:0] mul_op_b;
    logic            mul_valid;
    logic [FE_W-1:0] mul_res;
    logic            mul_done;

    modport master (
        output valid, p_x, p_y, p_z, mul_res, mul_done,
        input  s, done, busy, mul_op_a, mul_op_b, mul_valid
    );

    modport slave (
        input  valid, p_x, p_y, p_z, mul_res, mul_done,
        output s, done, busy, mul_op_a, mul_op_b, mul_valid
    );
endinterface

// File: rtl/ge_tobytes.sv
// ge_tobytes: compress projective (X:Y:Z) to 32 bytes via Z^(p-2) on a shared multiplier.
module ge_tobytes (
    input logic         clk,
    input logic         rst,
    ge_tobytes_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, INV_SQ, INV_SQ_W, INV_MUL, INV_MUL_W, NEXT,
        MUL_X, MUL_X_W, MUL_Y, MUL_Y_W, FREEZE, DONE
    } state_t;

    // p-2 has every bit above 4 set; only the low five bits vary
    localparam logic [7:0] E_LO = 8'h0b;

    state_t       state;
    logic [319:0] x, y, z, acc, xr, yr;
    logic [7:0]   cnt;
    logic [254:0] yc, xc_w, yc_w;
    logic         xneg, e_bit;

    function automatic logic [254:0] fe_freeze(input logic [319:0] f);
        logic signed [63:0] h [10];
        logic signed [63:0] q, c;
        logic [254:0]       r;
        int                 off;
        for (int i = 0; i < 10; i++) h[i] = {{32{f[32*i+31]}}, f[32*i +: 32]};
        q = (64'sd19 * h[9] + 64'sd16777216) >>> 25;
        for (int i = 0; i < 10; i++) q = (h[i] + q) >>> (i[0] ? 25 : 26);
        h[0] = h[0] + 64'sd19 * q;
        for (int i = 0; i < 9; i++) begin
            c = h[i] >>> (i[0] ? 25 : 26);
            h[i+1] = h[i+1] + c;
            h[i] = h[i] - (c <<< (i[0] ? 25 : 26));
        end
        h[9] = h[9] - ((h[9] >>> 25) <<< 25);
        r = '0;
        off = 0;
        for (int i = 0; i < 10; i++) begin
            r = r | (255'(h[i][25:0]) << off);
            off = off + (i[0] ? 25 : 26);
        end
        return r;
    endfunction

    assign e_bit = (cnt > 8'd4) || E_LO[cnt[2:0]];

    always_comb begin
        xc_w = fe_freeze(xr);
        yc_w = fe_freeze(yr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            bus.s        <= '0;
            bus.done     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.mul_valid <= 1'b0;
            bus.mul_op_a <= '0;
            bus.mul_op_b <= '0;
            x            <= '0;
            y            <= '0;
            z            <= '0;
            acc          <= '0;
            xr           <= '0;
            yr           <= '0;
            cnt          <= '0;
            yc           <= '0;
            xneg         <= 1'b0;
        end else begin
            bus.mul_valid <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    // busy is still high in the done cycle, so a start there is dropped
                    if (bus.valid && !bus.busy) begin
                        x        <= bus.p_x;
                        y        <= bus.p_y;
                        z        <= bus.p_z;
                        acc      <= bus.p_z;
                        cnt      <= 8'd253;
                        bus.busy <= 1'b1;
                        state    <= INV_SQ;
                    end
                end
                INV_SQ: begin
                    bus.mul_valid <= 1'b1;
                    bus.mul_op_a  <= acc;
                    bus.mul_op_b  <= acc;
                    state         <= INV_SQ_W;
                end
                INV_SQ_W: if (bus.mul_done) begin
                    acc   <= bus.mul_res;
                    state <= e_bit ? INV_MUL : NEXT;
                end
                INV_MUL: begin
                    bus.mul_valid <= 1'b1;
                    bus.mul_op_a  <= acc;
                    bus.mul_op_b  <= z;
                    state         <= INV_MUL_W;
                end
                INV_MUL_W: if (bus.mul_done) begin
                    acc   <= bus.mul_res;
                    state <= NEXT;
                end
                NEXT: begin
                    cnt   <= (cnt == 8'd0) ? cnt : cnt - 8'd1;
                    state <= (cnt == 8'd0) ? MUL_X : INV_SQ;
                end
                MUL_X: begin
                    bus.mul_valid <= 1'b1;
                    bus.mul_op_a  <= x;
                    bus.mul_op_b  <= acc;
                    state         <= MUL_X_W;
                end
                MUL_X_W: if (bus.mul_done) begin
                    xr    <= bus.mul_res;
                    state <= MUL_Y;
                end
                MUL_Y: begin
                    bus.mul_valid <= 1'b1;
                    bus.mul_op_a  <= y;
                    bus.mul_op_b  <= acc;
                    state         <= MUL_Y_W;
                end
                MUL_Y_W: if (bus.mul_done) begin
                    yr    <= bus.mul_res;
                    state <= FREEZE;
                end
                FREEZE: begin
                    yc    <= yc_w;
                    xneg  <= xc_w[0];
                    state <= DONE;
                end
                DONE: begin
                    bus.s    <= {xneg, yc};
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ge_tobytes.sv
// tb_ge_tobytes: directed encodes against a modular-arithmetic multiplier model.
module tb_ge_tobytes;
    localparam logic [255:0] P   = 256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
    localparam logic [255:0] B_X = 256'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
    localparam logic [255:0] B_Y = 256'h6666666666666666666666666666666666666666666666666666666666666658;

    logic clk, rst;
    int   n_chk, n_pass, mv_cnt, d_cnt;

    ge_tobytes_if b ();
    ge_tobytes dut (.clk(clk), .rst(rst), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [255:0] fe_val(input logic [319:0] f);
        logic signed [300:0] a;
        logic signed [31:0]  l;
        int                  off;
        a = '0;
        off = 0;
        for (int i = 0; i < 10; i++) begin
            l = f[32*i +: 32];
            a = a + (301'(l) <<< off);
            off += (i % 2 == 1) ? 25 : 26;
        end
        a = a % $signed({45'b0, P});
        if (a < 0) a = a + $signed({45'b0, P});
        return a[255:0];
    endfunction

    function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y);
        logic [511:0] pr;
        pr = {256'b0, x} * {256'b0, y};
        pr = pr % {256'b0, P};
        return pr[255:0];
    endfunction

    function automatic logic [319:0] to_limbs(input logic [255:0] v);
        logic [319:0] f;
        logic [255:0] t;
        int           off;
        off = 0;
        for (int i = 0; i < 10; i++) begin
            t = v >> off;
            f[32*i +: 32] = (i == 9) ? {6'b0, t[25:0]} : ((i % 2 == 1) ? {7'b0, t[24:0]} : {6'b0, t[25:0]});
            off += (i % 2 == 1) ? 25 : 26;
        end
        return f;
    endfunction

    // Returns products in rotating representations so the final reduction is exercised.
    function automatic logic [319:0] repr(input logic [255:0] r, input int mode);
        logic [319:0] f;
        f = to_limbs(mode == 1 ? r + P : r);
        if (mode == 2) begin
            f[31:0]  = f[31:0] + 32'h4000000;
            f[63:32] = f[63:32] - 32'd1;
        end
        return f;
    endfunction

    initial begin
        logic [319:0] oa, ob;
        int           mc;
        mc = 0;
        b.mul_done = 1'b0;
        b.mul_res  = '0;
        forever begin
            @(negedge clk);
            if (b.mul_valid) begin
                oa = b.mul_op_a;
                ob = b.mul_op_b;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                b.mul_res  = repr(mulmod(fe_val(oa), fe_val(ob)), mc % 3);
                b.mul_done = 1'b1;
                mc++;
                @(negedge clk);
                b.mul_done = 1'b0;
            end
        end
    end

    initial begin
        mv_cnt = 0;
        d_cnt  = 0;
        forever begin
            @(negedge clk);
            if (b.mul_valid) mv_cnt++;
            if (b.done) d_cnt++;
        end
    end

    task automatic encode(input string tag, input logic [319:0] px, input logic [319:0] py,
                          input logic [319:0] pz, input logic [255:0] exp_s, input logic stray);
        int m0, d0, k;
        m0 = mv_cnt;
        d0 = d_cnt;
        b.p_x = px;
        b.p_y = py;
        b.p_z = pz;
        b.valid = 1'b1;
        @(negedge clk);
        b.valid = 1'b0;
        if (stray) begin
            repeat (100) @(negedge clk);
            b.p_y = to_limbs(256'd1);
            b.valid = 1'b1;
            @(negedge clk);
            b.valid = 1'b0;
        end
        k = 0;
        while (!b.done && k < 8000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, 320'(b.done), 320'd1);
        check({tag, "_s"}, 320'(b.s), 320'(exp_s));
        check({tag, "_busy_at_done"}, 320'(b.busy), 320'd1);
        check({tag, "_mul_count"}, 320'(mv_cnt - m0), 320'd508);
        @(negedge clk);
        check({tag, "_done_pulse"}, 320'(b.done), 320'd0);
        check({tag, "_busy_after"}, 320'(b.busy), 320'd0);
        check({tag, "_done_count"}, 320'(d_cnt - d0), 320'd1);
    endtask

    initial begin
        logic [319:0] y_p1, y_m1;
        int           d0;
        n_chk = 0;
        n_pass = 0;
        rst = 1'b0;
        b.valid = 1'b0;
        b.p_x = '0;
        b.p_y = '0;
        b.p_z = '0;
        repeat (3) @(negedge clk);
        check("rst_s", 320'(b.s), 320'd0);
        check("rst_done", 320'(b.done), 320'd0);
        check("rst_busy", 320'(b.busy), 320'd0);
        check("rst_mul_valid", 320'(b.mul_valid), 320'd0);
        check("rst_op_a", b.mul_op_a, 320'd0);
        check("rst_op_b", b.mul_op_b, 320'd0);
        rst = 1'b1;
        @(negedge clk);

        encode("identity", to_limbs(256'd0), to_limbs(256'd1), to_limbs(256'd1), 256'd1, 1'b0);
        encode("scaled_identity", to_limbs(256'd0), to_limbs(256'd2), to_limbs(256'd2), 256'd1, 1'b0);
        encode("base", to_limbs(B_X), to_limbs(B_Y), to_limbs(256'd1), B_Y, 1'b1);
        encode("neg_base", to_limbs(P - B_X), to_limbs(B_Y), to_limbs(256'd1),
               256'he666666666666666666666666666666666666666666666666666666666666658, 1'b0);
        encode("base_z3", to_limbs(mulmod(B_X, 256'd3)), to_limbs(mulmod(B_Y, 256'd3)),
               to_limbs(256'd3), B_Y, 1'b0);

        y_p1 = '0;
        for (int i = 0; i < 10; i++) y_p1[32*i +: 32] = (i % 2 == 1) ? 32'h1ffffff : 32'h3ffffff;
        y_p1[31:0] = 32'h3ffffee;
        encode("y_p_plus_1", to_limbs(256'd0), y_p1, to_limbs(256'd1), 256'd1, 1'b0);
        y_m1 = '0;
        y_m1[31:0] = 32'hffffffff;
        encode("y_minus_1", to_limbs(256'd0), y_m1, to_limbs(256'd1), P - 256'd1, 1'b0);
        encode("z_zero", to_limbs(B_X), to_limbs(B_Y), to_limbs(256'd0), 256'd0, 1'b0);

        d0 = d_cnt;
        b.p_x = to_limbs(B_X);
        b.p_y = to_limbs(B_Y);
        b.p_z = to_limbs(256'd1);
        b.valid = 1'b1;
        @(negedge clk);
        b.valid = 1'b0;
        repeat (600) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_s", 320'(b.s), 320'd0);
        check("abort_busy", 320'(b.busy), 320'd0);
        check("abort_done", 320'(b.done), 320'd0);
        check("abort_mul_valid", 320'(b.mul_valid), 320'd0);
        check("abort_op_a", b.mul_op_a, 320'd0);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_done", 320'(d_cnt - d0), 320'd0);
        check("abort_idle", 320'(b.busy), 320'd0);
        encode("after_abort", to_limbs(256'd0), to_limbs(256'd1), to_limbs(256'd1), 256'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
